// File: rtl/capture_thresh_load_ctrl_if.sv
// Bus bundle between the load_thresh register path, the threshold RAM
// write port and the status register for capture_thresh_load_ctrl.
interface capture_thresh_load_ctrl_if #(
  parameter int CHAN_BITS   = 8,
  parameter int THRESH_BITS = 16
);
  logic [31:0]            reg_data;
  logic                   wr_ok;
  logic                   thr_we;
  logic [CHAN_BITS-1:0]   thr_addr;
  logic [THRESH_BITS-1:0] thr_data;
  logic                   busy;
  logic [31:0]            status;

  // Side that supplies the register word and the RAM port grant.
  modport master (
    output reg_data, wr_ok,
    input  thr_we, thr_addr, thr_data, busy, status
  );

  // Controller side.
  modport slave (
    input  reg_data, wr_ok,
    output thr_we, thr_addr, thr_data, busy, status
  );
endinterface

// File: rtl/capture_thresh_load_ctrl.sv
// Sequences software threshold loads into the capture block's per-channel
// threshold RAM: one channel or a sweep of every channel, gated by wr_ok.
module capture_thresh_load_ctrl #(
  parameter int CHAN_BITS   = 8,
  parameter int THRESH_BITS = 16
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  capture_thresh_load_ctrl_if.slave    bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITE_ONE = 2'd1;
  localparam logic [1:0] SWEEP     = 2'd2;

  localparam logic [CHAN_BITS-1:0] LAST_CHAN = {CHAN_BITS{1'b1}};

  logic [1:0]             state;
  logic                   load_prev;
  logic                   load_edge;
  logic [CHAN_BITS-1:0]   chan_lat;
  logic [THRESH_BITS-1:0] thr_lat;
  logic [CHAN_BITS-1:0]   sweep_addr;
  logic                   overrun;
  logic [15:0]            load_count;
  logic                   thr_we;
  logic [CHAN_BITS-1:0]   thr_addr;
  logic [THRESH_BITS-1:0] thr_data;

  // Rising edge of the software load bit.
  assign load_edge = bus.reg_data[31] & ~load_prev;

  // Control state, latched fields, RAM write port and status counters.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      // NOTE: all state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state      <= IDLE;
      load_prev  <= 1'b1;  // a load bit held through reset is not an edge
      chan_lat   <= '0;
      thr_lat    <= '0;
      sweep_addr <= '0;
      overrun    <= 1'b0;
      load_count <= '0;
      thr_we     <= 1'b0;
      thr_addr   <= '0;
      thr_data   <= '0;
    end else begin
      load_prev <= bus.reg_data[31];
      thr_we    <= 1'b0;

      // An edge while an operation is running is only recorded.
      if (load_edge && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_edge) begin
            chan_lat   <= bus.reg_data[16 +: CHAN_BITS];
            thr_lat    <= bus.reg_data[THRESH_BITS-1:0];
            sweep_addr <= '0;
            state      <= bus.reg_data[30] ? SWEEP : WRITE_ONE;
          end
        end

        WRITE_ONE: begin
          if (bus.wr_ok) begin
            thr_we     <= 1'b1;
            thr_addr   <= chan_lat;
            thr_data   <= thr_lat;
            load_count <= load_count + 16'd1;
            state      <= IDLE;
          end
        end

        SWEEP: begin
          if (bus.wr_ok) begin
            thr_we   <= 1'b1;
            thr_addr <= sweep_addr;
            thr_data <= thr_lat;
            if (sweep_addr == LAST_CHAN) begin
              load_count <= load_count + 16'd1;
              state      <= IDLE;
            end else begin
              sweep_addr <= sweep_addr + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.thr_we   = thr_we;
  assign bus.thr_addr = thr_addr;
  assign bus.thr_data = thr_data;
  assign bus.busy     = (state != IDLE);
  assign bus.status   = {(state != IDLE), overrun, 14'd0, load_count};

endmodule

// File: tb/tb_capture_thresh_load_ctrl.sv
// Randomised scoreboard bench for capture_thresh_load_ctrl: stimulus pushes
// the expected RAM writes, a monitor pops them as thr_we pulses appear.
module tb_capture_thresh_load_ctrl;

  localparam int CB = 8;
  localparam int TB = 16;
  localparam int NCH = 1 << CB;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic OPB_Clk = 1'b0;
  logic OPB_Rst = 1'b1;

  capture_thresh_load_ctrl_if #(.CHAN_BITS(CB), .THRESH_BITS(TB)) bus ();

  capture_thresh_load_ctrl #(.CHAN_BITS(CB), .THRESH_BITS(TB)) dut (
    .OPB_Clk (OPB_Clk),
    .OPB_Rst (OPB_Rst),
    .bus     (bus)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];
  int  exp_count   = 0;
  int  exp_overrun = 0;
  int  wr_mode     = 1;  // 0: low, 1: high, 2: toggle, 3: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // wr_ok grant pattern, changed just after each rising edge.
  initial bus.wr_ok = 1'b1;
  always @(posedge OPB_Clk) begin
    #1;
    case (wr_mode)
      0:       bus.wr_ok = 1'b0;
      1:       bus.wr_ok = 1'b1;
      2:       bus.wr_ok = ~bus.wr_ok;
      default: bus.wr_ok = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every write pulse must match the next expected write.
  always @(negedge OPB_Clk) begin
    if (!OPB_Rst && bus.thr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(bus.thr_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.thr_addr), e.addr);
        check("wr_data", 32'(bus.thr_data), e.data);
      end
    end
  end

  // Reference: what a load request does, from the register word alone.
  function automatic logic [31:0] fld_chan(input logic [31:0] w);
    return (w >> 16) & 32'(NCH - 1);
  endfunction

  function automatic logic [31:0] fld_thr(input logic [31:0] w);
    return w & 32'((1 << TB) - 1);
  endfunction

  task automatic push_expected(input logic [31:0] w);
    wr_t e;
    if (w[30]) begin
      for (int a = 0; a < NCH; a++) begin
        e.addr = 32'(a);
        e.data = fld_thr(w);
        exp_q.push_back(e);
      end
    end else begin
      e.addr = fld_chan(w);
      e.data = fld_thr(w);
      exp_q.push_back(e);
    end
  endtask

  // Present the word with load low for a cycle, then raise load.
  // Returns just after the edge that makes cycle n the request cycle.
  task automatic issue(input logic [31:0] w, input bit expect_accept);
    @(posedge OPB_Clk); #1;
    bus.reg_data = {1'b0, w[30:0]};
    @(posedge OPB_Clk); #1;
    bus.reg_data = {1'b1, w[30:0]};
    if (expect_accept) push_expected({1'b1, w[30:0]});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge OPB_Clk); #1;
      n++;
    end
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge OPB_Clk);
  endtask

  task automatic check_status(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_status"}, bus.status,
          {1'b0, 1'(exp_overrun), 14'd0, 16'(exp_count)});
  endtask

  initial begin
    logic [31:0] w;
    bus.reg_data = 32'd0;

    // Reset state.
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    check("rst_thr_we", 32'(bus.thr_we), 32'd0);
    check("rst_thr_addr", 32'(bus.thr_addr), 32'd0);
    check("rst_thr_data", 32'(bus.thr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_status", bus.status, 32'd0);
    OPB_Rst = 1'b0;

    // Single write with exact latency.
    wr_mode = 1;
    issue(32'h0005_1234, 1'b1);
    @(negedge OPB_Clk);
    check("single_n_busy", 32'(bus.busy), 32'd0);
    @(negedge OPB_Clk);
    check("single_n1_busy", 32'(bus.busy), 32'd1);
    check("single_n1_we", 32'(bus.thr_we), 32'd0);
    @(negedge OPB_Clk);
    check("single_n2_we", 32'(bus.thr_we), 32'd1);
    check("single_n2_busy", 32'(bus.busy), 32'd0);
    @(negedge OPB_Clk);
    check("single_n3_we", 32'(bus.thr_we), 32'd0);
    exp_count++;
    drain("single");
    check_status("single");

    // Stall: wr_ok low for five cycles inside WRITE_ONE.
    wr_mode = 0;
    repeat (2) @(posedge OPB_Clk);
    issue(32'h0005_1234, 1'b1);
    @(negedge OPB_Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge OPB_Clk);
      check("stall_we", 32'(bus.thr_we), 32'd0);
      check("stall_busy", 32'(bus.busy), 32'd1);
    end
    wr_mode = 1;
    exp_count++;
    drain("stall");
    check_status("stall");

    // Sweep with wr_ok toggling.
    wr_mode = 2;
    issue(32'h4000_0100, 1'b1);
    exp_count++;
    drain("sweep");
    check_status("sweep");

    // Overrun: second load edge mid-sweep is ignored but recorded.
    wr_mode = 3;
    w = $urandom();
    w[30] = 1'b1;
    issue(w, 1'b1);
    while (exp_q.size() > 200) begin
      @(negedge OPB_Clk); #1;
    end
    bus.reg_data = 32'h0000_0000;
    @(posedge OPB_Clk); #1;
    bus.reg_data = 32'h8012_5555;
    exp_count++;
    exp_overrun = 1;
    drain("overrun");
    check_status("overrun");

    // Random single loads; overrun must stay sticky.
    for (int i = 0; i < 10; i++) begin
      w = $urandom();
      w[30] = 1'b0;
      wr_mode = 1 + int'($urandom_range(0, 2));
      issue(w, 1'b1);
      exp_count++;
      drain("rand_single");
      check_status("rand_single");
    end

    // Reset at write 100 of a sweep, load bit held high.
    wr_mode = 1;
    issue(32'h4000_0777, 1'b1);
    while (exp_q.size() > NCH - 100) begin
      @(negedge OPB_Clk); #1;
    end
    OPB_Rst = 1'b1;
    exp_q.delete();
    exp_count = 0;
    exp_overrun = 0;
    @(negedge OPB_Clk);
    check("midrst_we", 32'(bus.thr_we), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_status", bus.status, 32'd0);
    OPB_Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge OPB_Clk);
      check("held_load_idle", 32'(bus.busy), 32'd0);
    end

    // Field masking: channel bits above CHAN_BITS ignored.
    issue(32'h8FFF_ABCD, 1'b1);
    exp_count++;
    drain("mask");
    check_status("mask");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_thresh_load_ctrl.md
Name: capture_thresh_load_ctrl

Overview:
- Sequences software-requested threshold updates into the channelizer capture block's per-channel threshold RAM.
- Takes the 32-bit word from the load_thresh software register (already in the fabric clock domain) and detects a rising edge on its load bit.
- On that edge, writes one channel's threshold or sweeps the same value into every channel.
- Writes happen only on cycles the datapath grants the RAM port (wr_ok). A status word returns to a ppc-readable register.

Parameters:
CHAN_BITS, 8, channel address width; number of channels is 2^CHAN_BITS; legal range 1..14.
THRESH_BITS, 16, threshold width; legal range 1..16.

Ports:
OPB_Clk  input  1  single clock; all logic on rising edge.
OPB_Rst  input  1  synchronous, active-high reset.
reg_data  input  32  software register word: [31]=load, [30]=all, [16+CHAN_BITS-1:16]=channel, [THRESH_BITS-1:0]=threshold.
wr_ok  input  1  datapath grants the threshold RAM write port this cycle.
thr_we  output  1  threshold RAM write enable, registered.
thr_addr  output  CHAN_BITS  threshold RAM address, registered.
thr_data  output  THRESH_BITS  threshold RAM data, registered.
busy  output  1  high while a load is in progress (state != IDLE).
status  output  32  [31]=busy, [30]=overrun sticky, [29:16]=0, [15:0]=completed-load count.

Behaviour:
- Clocking and reset: one clock, OPB_Clk. Reset is synchronous and active-high on OPB_Rst.
- Reset values:
  - thr_we=0, thr_addr=0, thr_data=0, busy=0.
  - overrun=0, load count=0, state=IDLE.
  - load_prev=1, so a load bit held high through reset produces no load.
- load_prev is registered from reg_data[31] every cycle. A rising edge in cycle n means reg_data[31]=1 and load_prev=0.
- FSM states:
  - IDLE -> WRITE_ONE on an edge with reg_data[30]=0.
  - IDLE -> SWEEP on an edge with reg_data[30]=1.
  - On either transition, channel and threshold are latched at the end of cycle n.
  - SWEEP starts its address counter at 0.
- WRITE_ONE:
  - On each cycle with wr_ok=1, register thr_we=1, thr_addr=channel, thr_data=threshold, and go to IDLE.
  - With wr_ok=0, stay in WRITE_ONE and register thr_we=0.
  - Latency with wr_ok held high: edge in cycle n, busy high in cycle n+1, thr_we high in cycle n+2, busy low in cycle n+2.
- SWEEP:
  - On each cycle with wr_ok=1, issue one write (thr_addr=counter, thr_data=threshold) and increment the counter.
  - On cycles with wr_ok=0, no write and the counter holds.
  - Exit to IDLE on the same edge that issues the write to address 2^CHAN_BITS-1. The counter does not wrap into a second pass.
  - With wr_ok held high, exactly 2^CHAN_BITS consecutive thr_we pulses.
- thr_we is high for exactly one cycle per issued write. thr_addr and thr_data hold their last values while thr_we=0.
- Load count:
  - Increments by 1 on the cycle the FSM returns to IDLE from either state.
  - 16-bit counter that wraps 0xFFFF -> 0.
- Overrun:
  - A rising edge while state != IDLE is ignored: latched fields are unchanged and the current operation continues.
  - That edge sets the overrun bit, which stays sticky until OPB_Rst.
- Edge and end-of-operation in the same cycle: the state is still non-IDLE in that cycle, so the edge is an overrun, not a new load.
- Reset mid-operation:
  - The operation aborts; the next cycle shows all outputs at reset values.
  - No further writes are issued, and the count does not increment for the aborted load.
- Field bits of reg_data above 16+CHAN_BITS-1 (other than 31 and 30) are ignored. Bits above THRESH_BITS-1 in [15:0] are ignored.
- Fields are sampled only at the edge; later changes to reg_data do not affect an operation in progress.

Test Plan:
- Single write:
  - Stimulus: after reset, reg_data=0x0005_1234, then 0x8005_1234, wr_ok=1.
  - Response: thr_we one cycle exactly 2 cycles after the edge, thr_addr=5, thr_data=0x1234, status[15:0]=1, busy low again.
- Stall:
  - Stimulus: same single write with wr_ok=0 for 5 cycles, then 1.
  - Response: no thr_we while stalled, busy held high, one write to channel 5 after wr_ok rises.
- Sweep:
  - Stimulus: reg_data=0xC000_0100 with wr_ok toggling 1,0,1,0...
  - Response: 256 writes, addresses 0..255 in order, each with data 0x0100; no repeated address; count increments once.
- Overrun:
  - Stimulus: toggle the load bit 0->1 again during a sweep.
  - Response: the sweep completes unchanged with 256 writes; status[30]=1 and stays 1 through further loads until OPB_Rst.
- Reset mid-sweep:
  - Stimulus: assert OPB_Rst at write 100 while reg_data[31] is still high.
  - Response: next cycle thr_we=0, busy=0, status=0; with load still held high after reset, no writes occur until the bit goes 0->1.
- Field masking:
  - Stimulus: with CHAN_BITS=8, reg_data=0x8FFF_ABCD (all=0).
  - Response: a single write with thr_addr=0xFF, thr_data=0xABCD.
